// File: rtl/mp_dist_ram_pkg.sv
// mp_dist_ram_pkg -- shared definitions for the multi-port distributed RAM.
//   state_t     : controller state encoding (ST_CLEAR = 0, ST_RUN = 1)
//   byte_merge  : per-byte select between stored and incoming data
// Optional feature macro used by the block: MP_DIST_RAM_BYPASS_EN.
package mp_dist_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Returns the incoming byte when its enable is set, else the stored byte.
  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       en
  );
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mp_dist_ram_rdport.sv
// mp_dist_ram_rdport -- one registered read port of mp_dist_ram.
// Optional feature macro: MP_DIST_RAM_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   i_run         : controller is in RUN; reads are accepted only then
//   i_rd_en       : read request for this port
//   i_ram_q       : asynchronous RAM word at this port's address
//   i_byp_hit     : an accepted write targets this port's address this cycle
//   i_byp_word    : the merged word being written on this edge
//   o_rd_data     : registered read data (holds when no read is accepted)
//   o_rd_valid    : one-cycle strobe per accepted read
module mp_dist_ram_rdport #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_rd_en,
  input  logic [DATA_W-1:0] i_ram_q,
  input  logic              i_byp_hit,
  input  logic [DATA_W-1:0] i_byp_word,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid
);

  logic              w_rd_acc;
  logic [DATA_W-1:0] w_next_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  assign w_rd_acc = i_run & i_rd_en;

`ifdef MP_DIST_RAM_BYPASS_EN
  // Forward the word being written so the read sees the post-write value.
  assign w_next_data = i_byp_hit ? i_byp_word : i_ram_q;
`else
  // Read-before-write: the array still holds the old word on this edge.
  assign w_next_data = i_ram_q;
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_byp_hit, i_byp_word};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_next_data;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/mp_dist_ram.sv
// mp_dist_ram -- DEPTH x DATA_W distributed RAM, one byte-enabled write port,
// NUM_RD registered read ports, self-clearing after reset.
// Optional feature macro: MP_DIST_RAM_BYPASS_EN. When defined, a read of the
// address being written on the same edge returns the new (merged) word;
// otherwise it returns the old word.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   wr_en/addr/be/data, wr_ready : write port
//   rd_en, rd_addr (packed NUM_RD*ADDR_W) : read requests
//   rd_data (packed NUM_RD*DATA_W), rd_valid : registered read results
//   init_done    : post-reset clear sweep finished
//   dbg_state    : controller state, for observation only
//
// Handshakes: a write is accepted on a rising edge where wr_en && wr_ready;
// a write with wr_ready low is dropped, never held. A read on port p is
// accepted on an edge where rd_en[p] && init_done, and rd_valid[p] is high
// for exactly the cycle after each accepted read. There is no back-pressure
// on reads.
module mp_dist_ram
  import mp_dist_ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int NUM_RD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     init_done,
  output state_t                   dbg_state
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  // Controller
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;
  logic              w_run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_run         = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        // Leave CLEAR on the edge that zeroes the last word.
        if (r_clr_ptr == {ADDR_W{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign wr_ready  = w_run;
  assign init_done = w_run;
  assign dbg_state = r_state;

  // Storage. No reset on the array: only the clear sweep zeroes it.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_acc;
  logic [DATA_W-1:0] w_old_word;
  logic [DATA_W-1:0] w_merged;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_din;

  assign w_wr_acc   = wr_en & w_run;
  assign w_old_word = r_mem[wr_addr];

  for (genvar b = 0; b < NBYTES; b++) begin : g_merge
    assign w_merged[8*b +: 8] = byte_merge(w_old_word[8*b +: 8],
                                           wr_data[8*b +: 8], wr_be[b]);
  end

  // rst_n gates the write so an asserted reset never disturbs contents.
  assign w_mem_we   = rst_n & (~w_run | (w_wr_acc & (|wr_be)));
  assign w_mem_addr = w_run ? wr_addr  : r_clr_ptr;
  assign w_mem_din  = w_run ? w_merged : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  // Read ports
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_q;
    logic              w_hit;

    assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];
    assign w_q    = r_mem[w_addr];
    assign w_hit  = w_wr_acc & (w_addr == wr_addr);

    mp_dist_ram_rdport #(
      .DATA_W(DATA_W)
    ) u_rdport (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_run      (w_run),
      .i_rd_en    (rd_en[p]),
      .i_ram_q    (w_q),
      .i_byp_hit  (w_hit),
      .i_byp_word (w_merged),
      .o_rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .o_rd_valid (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_mp_dist_ram.sv
// tb_mp_dist_ram -- directed bench for mp_dist_ram: default configuration
// plus a DATA_W=32/ADDR_W=4/NUM_RD=2 instance. Honours MP_DIST_RAM_BYPASS_EN
// when computing same-edge write/read expectations.
module tb_mp_dist_ram;
  import mp_dist_ram_pkg::*;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NR = 4;

`ifdef MP_DIST_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW/8-1:0]  wr_be;
  logic [DW-1:0]    wr_data;
  logic             wr_ready;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic             init_done;
  state_t           dbg_state;

  mp_dist_ram #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .init_done(init_done), .dbg_state(dbg_state)
  );

  // Wide/shallow instance
  logic        wr_en_b;
  logic [3:0]  wr_addr_b;
  logic [3:0]  wr_be_b;
  logic [31:0] wr_data_b;
  logic        wr_ready_b;
  logic [1:0]  rd_en_b;
  logic [7:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_valid_b;
  logic        init_done_b;
  state_t      dbg_state_b;

  mp_dist_ram #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_be(wr_be_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b),
    .init_done(init_done_b), .dbg_state(dbg_state_b)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_be_b = '0; wr_data_b = '0;
    rd_en_b = '0; rd_addr_b = '0;
  endtask

  // Runs the clear sweep after rst_n has been released, with all read ports
  // requesting and one write attempted after edge wr_at. Returns the edge
  // number (counted from release) at which each init_done was seen high.
  task automatic wait_init(input int wr_at, input logic [AW-1:0] waddr,
                           output int cyc_a, output int cyc_b);
    int bad_valid;
    cyc_a = -1;
    cyc_b = -1;
    bad_valid = 0;
    rd_en = '1;
    rd_addr = {6'd63, 6'd7, 6'd3, 6'd0};
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (!init_done && rd_valid != '0) bad_valid++;
      if (init_done && cyc_a < 0) cyc_a = c;
      if (init_done_b && cyc_b < 0) cyc_b = c;
      if (c == 20) check("clear_wr_ready_low", {63'd0, wr_ready}, 64'd0);
      if (c == wr_at) begin
        wr_en = 1'b1; wr_addr = waddr; wr_be = 2'b11; wr_data = 16'hFFFF;
      end else begin
        wr_en = 1'b0;
      end
      if (cyc_a >= 0 && cyc_b >= 0) break;
    end
    rd_en = '0;
    wr_en = 1'b0;
    check("clear_rd_valid_stays_0", 64'(bad_valid), 64'd0);
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a,
                         input logic [DW-1:0] exp);
    logic [NR-1:0] ev;
    ev = '0;
    ev[p] = 1'b1;
    rd_en = ev;
    rd_addr[p*AW +: AW] = a;
    tick();
    check($sformatf("read_valid_p%0d_a%0d", p, a), 64'(rd_valid), 64'(ev));
    check($sformatf("read_data_p%0d_a%0d", p, a),
          64'(rd_data[p*DW +: DW]), 64'(exp));
    rd_en = '0;
  endtask

  // Vector table
  typedef struct packed {
    logic             we;
    logic [AW-1:0]    wa;
    logic [1:0]       be;
    logic [DW-1:0]    wd;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] ra;
    logic [NR-1:0]    ev;
    logic [NR-1:0]    ck;
    logic [NR*DW-1:0] ed;
  } vec_t;

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [1:0] be,
                              logic [DW-1:0] wd, logic [NR-1:0] re,
                              logic [NR*AW-1:0] ra, logic [NR-1:0] ev,
                              logic [NR-1:0] ck, logic [NR*DW-1:0] ed);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.re = re; v.ra = ra;
    v.ev = ev; v.ck = ck; v.ed = ed;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int cyc_a;
    int cyc_b;
    logic [DW-1:0] e7, e9, e10;

    e7  = BYP ? 16'h1234 : 16'h0000;
    e9  = BYP ? 16'h5678 : 16'h1234;
    e10 = BYP ? 16'h56AB : 16'h5678;

    vecs[0]  = mk(1'b1, 6'd5,  2'b11, 16'hBEEF, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    vecs[1]  = mk(1'b1, 6'd5,  2'b01, 16'h0012, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    vecs[2]  = mk(1'b0, 6'd0,  2'b00, 16'h0000, 4'b1111,
                  {6'd0, 6'd63, 6'd5, 6'd5}, 4'b1111, 4'b1111,
                  {16'h0000, 16'h0000, 16'hBE12, 16'hBE12});
    vecs[3]  = mk(1'b1, 6'd9,  2'b00, 16'hFFFF, 4'b0000, '0, 4'b0000, 4'b1111,
                  {16'h0000, 16'h0000, 16'hBE12, 16'hBE12});
    vecs[4]  = mk(1'b0, 6'd0,  2'b00, 16'h0000, 4'b0010,
                  {6'd0, 6'd0, 6'd9, 6'd0}, 4'b0010, 4'b1111,
                  {16'h0000, 16'h0000, 16'h0000, 16'hBE12});
    vecs[5]  = mk(1'b1, 6'd63, 2'b10, 16'hA5C3, 4'b0000, '0, 4'b0000, 4'b0000, '0);
    vecs[6]  = mk(1'b0, 6'd0,  2'b00, 16'h0000, 4'b1001,
                  {6'd63, 6'd0, 6'd0, 6'd5}, 4'b1001, 4'b1001,
                  {16'hA500, 16'h0000, 16'h0000, 16'hBE12});
    vecs[7]  = mk(1'b1, 6'd7,  2'b11, 16'h1234, 4'b0100,
                  {6'd0, 6'd7, 6'd0, 6'd0}, 4'b0100, 4'b0100,
                  {16'h0000, e7, 16'h0000, 16'h0000});
    vecs[8]  = mk(1'b0, 6'd0,  2'b00, 16'h0000, 4'b0100,
                  {6'd0, 6'd7, 6'd0, 6'd0}, 4'b0100, 4'b0100,
                  {16'h0000, 16'h1234, 16'h0000, 16'h0000});
    vecs[9]  = mk(1'b1, 6'd7,  2'b11, 16'h5678, 4'b1111,
                  {6'd7, 6'd7, 6'd7, 6'd7}, 4'b1111, 4'b1111, {4{e9}});
    vecs[10] = mk(1'b1, 6'd7,  2'b01, 16'h00AB, 4'b0001,
                  {6'd0, 6'd0, 6'd0, 6'd7}, 4'b0001, 4'b0001,
                  {16'h0000, 16'h0000, 16'h0000, e10});

    // Reset state
    idle();
    rst_n = 1'b0;
    tick(); tick(); tick();
    check("rst_init_done",  {63'd0, init_done}, 64'd0);
    check("rst_wr_ready",   {63'd0, wr_ready}, 64'd0);
    check("rst_rd_valid",   64'(rd_valid), 64'd0);
    check("rst_rd_data",    rd_data, 64'd0);
    check("rst_state",      64'(dbg_state), 64'(ST_CLEAR));
    check("rst_b_init_done", {63'd0, init_done_b}, 64'd0);

    // Clear sweep after first release; write at edge 31 lands on address 3
    // after the sweep has passed it, so it must be dropped.
    rst_n = 1'b1;
    wait_init(30, 6'd3, cyc_a, cyc_b);
    check("init_cycles",   64'(cyc_a), 64'd64);
    check("init_cycles_b", 64'(cyc_b), 64'd16);
    check("run_wr_ready",  {63'd0, wr_ready}, 64'd1);
    check("run_state",     64'(dbg_state), 64'(ST_RUN));
    do_read(0, 6'd3,  16'h0000);
    do_read(1, 6'd40, 16'h0000);

    // Table
    for (int i = 0; i < NV; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_be = vecs[i].be;
      wr_data = vecs[i].wd; rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].ev));
      for (int p = 0; p < NR; p++) begin
        if (vecs[i].ck[p]) begin
          check($sformatf("vec%0d_data_p%0d", i, p),
                64'(rd_data[p*DW +: DW]), 64'(vecs[i].ed[p*DW +: DW]));
        end
      end
    end
    idle();
    tick();
    check("hold_valid_clear", 64'(rd_valid), 64'd0);

    // 32-bit instance: upper-byte-only write over a full word
    wr_en_b = 1'b1; wr_addr_b = 4'd2; wr_be_b = 4'b1111; wr_data_b = 32'h11223344;
    tick();
    wr_be_b = 4'b1000; wr_data_b = 32'hAA000000;
    tick();
    wr_en_b = 1'b0;
    rd_en_b = 2'b11; rd_addr_b = {4'd2, 4'd15};
    tick();
    rd_en_b = 2'b00;
    check("b_valid",   64'(rd_valid_b), 64'd3);
    check("b_data_p1", 64'(rd_data_b[63:32]), 64'h00000000AA223344);
    check("b_data_p0", 64'(rd_data_b[31:0]),  64'd0);

    // Reset in RUN, then again at clear cycle 30; the restarted sweep must
    // take the full 64 cycles and drop a write attempted mid-clear.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    check("midclear_init_low", {63'd0, init_done}, 64'd0);
    rst_n = 1'b0;
    tick();
    check("midclear_rst_state", 64'(dbg_state), 64'(ST_CLEAR));
    rst_n = 1'b1;
    wait_init(10, 6'd1, cyc_a, cyc_b);
    check("reinit_cycles",   64'(cyc_a), 64'd64);
    check("reinit_cycles_b", 64'(cyc_b), 64'd16);
    do_read(2, 6'd1,  16'h0000);
    do_read(3, 6'd5,  16'h0000);
    do_read(0, 6'd63, 16'h0000);
    do_read(1, 6'd7,  16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
